// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads take absolute priority, pixel writes use idle slots.
// Optional full-screen clear engine enabled by defining VRAM_CLEAR_EN.
module vram_arbiter #(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 12,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rgb,
  output logic              disp_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK   = 2'd1
`ifdef VRAM_CLEAR_EN
    ,S_CLEAR = 2'd2
`endif
  } state_t;

  state_t              r_state;
  logic                r_rd_pend;
  logic                r_disp_valid;
  logic [DATA_W-1:0]   r_disp_rgb;
  logic                r_wr_ack;
  logic                w_wr_gnt;
  logic                w_clr_go;
  logic                w_clr_wr;

`ifdef VRAM_CLEAR_EN
  logic [ADDR_W-1:0]   r_clr_addr;
  logic                r_clear_busy;

  assign w_clr_go   = (r_state == S_IDLE) && clear_start;
  assign w_clr_wr   = (r_state == S_CLEAR) && !disp_req;
  assign clear_busy = r_clear_busy;
`else
  logic                w_unused;

  assign w_clr_go   = 1'b0;
  assign w_clr_wr   = 1'b0;
  assign clear_busy = 1'b0;
  assign w_unused   = ^{clear_start, CLEAR_COLOR};
`endif

  // A CPU write is only granted from IDLE, so a held request is never committed twice.
  assign w_wr_gnt = (r_state == S_IDLE) && wr_req && !disp_req && !w_clr_go;

  assign disp_rgb   = r_disp_rgb;
  assign disp_valid = r_disp_valid;
  assign wr_ack     = r_wr_ack;

  // Per-cycle grant: display read > clear write > CPU write.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!reset) begin
      if (disp_req) begin
        ram_en   = 1'b1;
        ram_addr = disp_addr;
      end
`ifdef VRAM_CLEAR_EN
      else if (w_clr_wr) begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = r_clr_addr;
        ram_wdata = CLEAR_COLOR;
      end
`endif
      else if (w_wr_gnt) begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = wr_addr;
        ram_wdata = wr_data;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rd_pend    <= 1'b0;
      r_disp_valid <= 1'b0;
      r_disp_rgb   <= '0;
      r_wr_ack     <= 1'b0;
`ifdef VRAM_CLEAR_EN
      r_clr_addr   <= '0;
      r_clear_busy <= 1'b0;
`endif
    end else begin
      // Read data arrives the cycle after the read edge; capture it one edge later.
      r_rd_pend    <= disp_req;
      r_disp_valid <= r_rd_pend;
      if (r_rd_pend) begin
        r_disp_rgb <= ram_rdata;
      end
      r_wr_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_clr_go) begin
`ifdef VRAM_CLEAR_EN
            r_state      <= S_CLEAR;
            r_clear_busy <= 1'b1;
            r_clr_addr   <= '0;
`endif
          end else if (w_wr_gnt) begin
            r_state  <= S_ACK;
            r_wr_ack <= 1'b1;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
        end
`ifdef VRAM_CLEAR_EN
        S_CLEAR: begin
          if (w_clr_wr) begin
            r_clr_addr <= r_clr_addr + ADDR_W'(1);
            if (&r_clr_addr) begin
              r_state      <= S_IDLE;
              r_clear_busy <= 1'b0;
            end
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port video RAM (VRAM, 1-cycle synchronous read) between two requesters:
  - the VGA display fetch path, which reads one pixel per display clock;
  - a pixel writer (CPU or drawing logic) using a req/ack handshake.
- Display reads have absolute priority so the scan-out never glitches; writes fill the idle slots.
- Sits between the VGA display unit (X/Y pixel coordinates, 12-bit RGB) and the VRAM macro, all on CLK100MHZ.

Parameters:
- ADDR_W, 16, VRAM address width; address = {Y[7:0], X[7:0]}.
- DATA_W, 12, pixel width (RGB 4:4:4).
- CLEAR_COLOR, 12'h000, fill value for the optional clear engine.

Ports:
- CLK100MHZ  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- disp_req  in  1  display read request; high for at most 1 cycle in every 2.
- disp_addr  in  ADDR_W  display pixel address; valid while disp_req=1.
- disp_rgb  out  DATA_W  registered read data for the display.
- disp_valid  out  1  1-cycle pulse; disp_rgb is valid.
- wr_req  in  1  write request; held high with wr_addr/wr_data stable until wr_ack.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write pixel.
- wr_ack  out  1  1-cycle registered pulse; write committed.
- clear_start  in  1  1-cycle pulse; start a full-screen clear (optional feature).
- clear_busy  out  1  clear in progress.
- ram_en  out  1  VRAM enable.
- ram_we  out  1  VRAM write enable.
- ram_addr  out  ADDR_W  VRAM address.
- ram_wdata  out  DATA_W  VRAM write data.
- ram_rdata  in  DATA_W  VRAM read data; valid the cycle after a read-enabled edge.

Behaviour:
- Reset:
  - Outputs disp_rgb=0, disp_valid=0, wr_ack=0, clear_busy=0.
  - ram_en, ram_we, ram_addr and ram_wdata are all 0 while reset is asserted.
  - FSM returns to IDLE and the clear counter goes to 0.
- Arbitration is combinational within each cycle. The ram_* outputs are driven from the current cycle's grant.
- Priority order: display read > clear write > CPU write.
- Display read:
  - In a cycle with disp_req=1: ram_en=1, ram_we=0, ram_addr=disp_addr.
  - ram_rdata is captured into disp_rgb on the following edge, with disp_valid=1 for one cycle.
  - Fixed latency: disp_req cycle N gives disp_valid in cycle N+2.
  - The display path is never stalled.
- FSM states:
  - IDLE: no write outstanding.
  - ACK: wr_ack=1 for this one cycle.
  - CLEAR: clear engine active.
- IDLE -> ACK:
  - Condition: wr_req=1, disp_req=0 and not clearing.
  - In that cycle: ram_en=1, ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data.
  - Next state is ACK.
- ACK -> IDLE unconditionally.
  - No write is granted in ACK, so a held wr_req is never written twice.
  - Display reads are still served in ACK.
- Write throughput is at most 1 write per 2 cycles.
- Worst-case write latency is 2 cycles from wr_req rise to the grant cycle, because disp_req is at most every other cycle.
- wr_req=1 and disp_req=1 in the same cycle: the read is served, the write waits, and the write is granted the next cycle.
- wr_req dropped before grant: nothing is written and no ack is issued.
- IDLE -> CLEAR on clear_start=1. clear_start is ignored when the FSM is not in IDLE.
- Write addresses wrap modulo 2^ADDR_W. No range checks are made.
- Reset asserted mid-operation:
  - Any outstanding ack is dropped.
  - An in-flight read produces no disp_valid.
  - A clear is aborted, leaving VRAM partially cleared.

Optional Feature:
- Macro: VRAM_CLEAR_EN.
- Defined:
  - CLEAR writes CLEAR_COLOR to addresses 0 .. 2^ADDR_W-1 in ascending order, using every cycle with disp_req=0.
  - clear_busy=1 from the cycle after clear_start until the cycle after the write to the last address; the FSM then returns to IDLE.
  - wr_ack is never issued during CLEAR; a pending wr_req waits until the clear finishes.
  - A clear_start received during CLEAR is ignored.
- Undefined:
  - No CLEAR state exists.
  - clear_start is ignored and clear_busy is tied to 0.

Test Plan:
- Reset behaviour: assert reset mid-write while wr_req=1 -> wr_ack=0, ram_en=0 and clear_busy=0 immediately; after release, the write is granted within 2 cycles.
- Read latency: preload VRAM addr 16'h1234=12'hABC, pulse disp_req with disp_addr=16'h1234 in cycle N -> disp_valid=1 and disp_rgb=12'hABC in cycle N+2.
- Conflict: disp_req alternating 1/0, wr_req held with 16'h0005/12'hF00 -> write granted only in a disp_req=0 cycle; exactly one wr_ack; readback of 0005 returns F00; all display reads return on time.
- Back-to-back writes: writer holds wr_req for 3 successive addresses, disp_req=0 -> grants every 2 cycles, 3 wr_acks, no duplicate ram_we for the same address.
- Clear (VRAM_CLEAR_EN defined, CLEAR_COLOR=12'h00F):
  - pulse clear_start with display streaming -> 65536 writes of 00F, no wr_ack during clear_busy, and disp_valid cadence unchanged.
  - Without the macro -> clear_busy stays 0 and VRAM contents are unchanged.
